// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : regfile_wb_arbiter
// Brief  : Round-robin arbiter for the shared register-file write port.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic [(2**AW)-1:0]   wr_onehot,
  output logic                 zr_drop
);

  localparam int            NREGS   = 2**AW;
  localparam int            PW      = $clog2(NREQ);
  localparam logic [AW-1:0] ZR_ADDR = {AW{1'b1}};

  logic [AW-1:0]    addr_w [NREQ];
  logic [DW-1:0]    data_w [NREQ];

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win;
  logic [PW:0]      idx_sum;
  logic             found;
  logic             xfer;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic             sel_zr;

  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [NREGS-1:0] wr_onehot_q, wr_onehot_d;
  logic             zr_drop_q, zr_drop_d;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_w[gi] = req_addr[gi*AW +: AW];
      assign data_w[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx_sum >= (PW+1)'(NREQ)) begin
        idx_sum = idx_sum - (PW+1)'(NREQ);
      end
      if (!found && req_valid[idx_sum[PW-1:0]]) begin
        found = 1'b1;
        win   = idx_sum[PW-1:0];
      end
    end
  end

  assign xfer      = found & ~stall & ~reset;
  assign req_ready = xfer ? (NREQ'(1) << win) : '0;
  assign sel_addr  = addr_w[win];
  assign sel_data  = data_w[win];
  assign sel_zr    = (sel_addr == ZR_ADDR);

  always_comb begin
    ptr_d       = ptr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    zr_drop_d   = 1'b0;
    wr_onehot_d = '0;
    if (xfer) begin
      ptr_d     = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      wr_en_d   = ~sel_zr;
      zr_drop_d = sel_zr;
      // Writes to the zero register are consumed without touching the decode.
      if (!sel_zr) begin
        wr_onehot_d = NREGS'(1) << sel_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_onehot_q <= '0;
      zr_drop_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_onehot_q <= wr_onehot_d;
      zr_drop_q   <= zr_drop_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_onehot = wr_onehot_q;
  assign zr_drop   = zr_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_regfile_wb_arbiter
// Brief  : Directed plus random stimulus against a round-robin reference model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int AW   = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [31:0]        wr_onehot;
  logic               zr_drop;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: pointer and the registered write expected after the edge.
  int            m_ptr;
  logic          e_en, e_zr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_onehot (wr_onehot),
    .zr_drop   (zr_drop)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    e_en   = 1'b0;
    e_zr   = 1'b0;
    e_addr = '0;
    e_data = '0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".wr_en"},     64'(wr_en),     64'(e_en));
    check_eq({tag, ".zr_drop"},   64'(zr_drop),   64'(e_zr));
    check_eq({tag, ".wr_addr"},   64'(wr_addr),   64'(e_addr));
    check_eq({tag, ".wr_data"},   wr_data,        e_data);
    check_eq({tag, ".wr_onehot"}, 64'(wr_onehot), e_en ? (64'd1 << e_addr) : 64'd0);
  endtask

  // Called just after a rising edge with inputs already set; checks at the
  // falling edge, then advances the model across the next rising edge.
  task automatic cycle(input string tag);
    int            w;
    logic [NREQ-1:0] g;
    w = stall ? -1 : pick(req_valid, m_ptr);
    g = (w >= 0) ? NREQ'(1) << w : '0;
    @(negedge clk);
    check_eq({tag, ".req_ready"}, 64'(req_ready), 64'(g));
    check_outputs(tag);
    @(posedge clk);
    if (w >= 0) begin
      e_addr = a[w];
      e_data = d[w];
      e_en   = (a[w] != 5'd31);
      e_zr   = (a[w] == 5'd31);
      m_ptr  = (w + 1) % NREQ;
    end else begin
      e_en = 1'b0;
      e_zr = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset     = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    stall     = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = AW'(i + 1);
      d[i] = 64'h1000 + 64'(i);
    end
    model_reset();
    #3;
    check_eq("rst.req_ready", 64'(req_ready), 64'd0);
    check_outputs("rst");
    @(posedge clk);
    #1;
    req_valid = '0;
    reset     = 1'b0;

    for (int i = 0; i < 5; i++) cycle("idle");

    req_valid = 4'b0010;
    a[1]      = 5'd5;
    d[1]      = 64'hDEAD_BEEF_0000_0001;
    cycle("single");
    req_valid = '0;
    cycle("single_out");

    do_reset();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) a[i] = AW'(i + 1);
    for (int i = 0; i < 8; i++) cycle("rr");
    req_valid = '0;
    cycle("rr_tail");

    do_reset();
    req_valid = 4'b0100;
    cycle("wrap_g2");
    req_valid = 4'b0101;
    cycle("wrap_g0");
    cycle("wrap_g2b");
    req_valid = '0;
    cycle("wrap_tail");

    req_valid = 4'b0001;
    a[0]      = 5'd31;
    cycle("xzr");
    req_valid = 4'b0001;
    a[0]      = 5'd7;
    cycle("xzr_after");
    req_valid = '0;
    cycle("xzr_tail");

    req_valid = '1;
    stall     = 1'b1;
    for (int i = 0; i < 3; i++) cycle("stall");
    stall = 1'b0;
    for (int i = 0; i < 3; i++) cycle("unstall");

    // Asynchronous reset while a registered write is live.
    check_eq("async.pre_wr_en", 64'(wr_en), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async.wr_en",     64'(wr_en),     64'd0);
    check_eq("async.wr_onehot", 64'(wr_onehot), 64'd0);
    check_eq("async.req_ready", 64'(req_ready), 64'd0);
    model_reset();
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    req_valid = '1;
    cycle("post_rst");
    check_eq("post_rst.first_addr", 64'(e_addr), 64'(a[0]));

    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom_range(7) == 0);
      req_valid = NREQ'($urandom);
      for (int j = 0; j < NREQ; j++) begin
        a[j] = ($urandom_range(5) == 0) ? 5'd31 : AW'($urandom);
        d[j] = {$urandom, $urandom};
      end
      cycle("rand");
    end
    req_valid = '0;
    stall     = 1'b0;
    cycle("rand_tail");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Round-robin arbiter sharing the single register-file write port between NREQ write-back requesters (ALU, load, multiply, branch-link).
- Each cycle it grants at most one requester and registers the winning address and data.
- It drives a 32-bit one-hot write-enable vector that feeds the register-file write decode.
- Writes to X31 (XZR) are accepted and silently discarded.

Parameters:
- NREQ, 4, number of write-back requesters (2..8).
- DW, 64, write data width.
- AW, 5, register address width. NREGS = 2**AW = 32.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline stall: freezes arbitration when high.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*AW  destination register; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*DW  write data; requester i uses bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant (combinational) for the current cycle.
- wr_en  output  1  registered register-file write enable.
- wr_addr  output  AW  registered write address.
- wr_data  output  DW  registered write data.
- wr_onehot  output  NREGS  registered decoded write enable; bit wr_addr is set when wr_en is high.
- zr_drop  output  1  registered one-cycle pulse when an accepted write targeted X31.

Behaviour:
- Reset (asynchronous, active-high):
  - ptr = 0.
  - wr_en, wr_addr, wr_data, wr_onehot and zr_drop all = 0.
  - req_ready = 0 while reset is asserted.
- Priority pointer:
  - ptr is a clog2(NREQ)-bit register.
  - Search order is ptr, ptr+1, … NREQ-1, 0, … ptr-1 (wrap-around).
  - The first requester with req_valid high wins.
- Grant:
  - When stall = 0, at least one valid is high, and reset = 0: req_ready[winner] = 1 and all other bits are 0.
  - req_ready is combinational from req_valid, ptr and stall.
  - It must not depend on req_addr or req_data.
- Transfer:
  - A transfer occurs on the clock edge where req_valid[i] and req_ready[i] are both high.
  - On transfer: ptr <= (winner+1) mod NREQ.
  - If there is no transfer, ptr holds.
- Output register (latency 1 cycle from transfer edge to wr_* valid):
  - Winner addr != 31:
    - wr_en = 1, wr_addr = addr, wr_data = data.
    - wr_onehot = 1 << addr.
    - zr_drop = 0.
  - Winner addr == 31:
    - wr_en = 0, wr_onehot = 0, zr_drop = 1.
    - wr_addr and wr_data are loaded anyway; they are don't-care to consumers.
    - ptr still advances.
  - No transfer: wr_en = 0, wr_onehot = 0, zr_drop = 0. wr_addr and wr_data hold their previous values.
- wr_en and wr_onehot are single-cycle per transfer. Back-to-back transfers give a continuous wr_en.
- Stall:
  - req_ready = 0 and ptr holds.
  - The next cycle has wr_en = 0.
  - Requesters keep valid, addr and data stable until granted. This is a protocol rule, not checked by the block.
- Deasserting a valid before it is granted is legal: that requester simply loses eligibility.
- No-request cycle: ptr holds and no output pulse is produced.
- Reset mid-operation: an in-flight registered write is cleared immediately (wr_en drops asynchronously), and ptr returns to 0.
- Invariants:
  - $onehot0(req_ready) always holds.
  - wr_onehot == (wr_en ? 1<<wr_addr : 0) always holds.
  - wr_onehot[31] is never set.

Test Plan:
- Reset release, no requests → req_ready = 0000, wr_en = 0, wr_onehot = 0 for 5 cycles; ptr stays 0.
- Single request: req_valid = 0010, addr1 = 5, data1 = 0xDEAD_BEEF_0000_0001 → same cycle req_ready = 0010; next cycle wr_en = 1, wr_addr = 5, wr_onehot = 0x0000_0020, wr_data matches.
- Round-robin fairness: req_valid = 1111 held for 8 cycles, addrs 1/2/3/4 → grants in order 0,1,2,3,0,1,2,3; wr_addr sequence 1,2,3,4,1,2,3,4; wr_en high for 8 consecutive cycles.
- Wrap and skip: ptr = 3 (after granting 2), req_valid = 0101 → grant 0, then ptr = 1 and grant 2 next cycle.
- XZR: a request with addr = 31 → req_ready asserted; next cycle wr_en = 0, wr_onehot = 0, zr_drop = 1; ptr advances.
- Stall and async reset: with req_valid = 1111, stall = 1 for 3 cycles → req_ready = 0000, wr_en = 0, ptr unchanged, then granting resumes from the same ptr. Reset asserted mid-cycle while wr_en = 1 → wr_en = 0 before the next edge; after release the first grant goes to requester 0.
